// File: rtl/mul8_seq_if.sv
// Request/status bundle of the sequential 8x8 multiplier.
// The master drives start/a/b. The slave reports busy/done/p and its FSM state.
interface mul8_seq_if;
    // Handshake: a request is start=1 at a rising edge while the slave is idle.
    // That edge is the accept, and a/b are captured there. start is ignored at every
    // other edge. There is no ready line: busy covers the multiply steps, done pulses
    // once with p valid, and p then holds until the next completion or reset.
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;
    logic [1:0]  state_dbg;

    modport master (output start, a, b, input busy, done, p, state_dbg);
    modport slave  (input start, a, b, output busy, done, p, state_dbg);
endinterface

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned multiplier that reuses one 4x4 array over four nibble steps.
// Optional MUL8_ZSKIP_EN skips steps whose nibble pair contains a zero nibble.
module mul4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] prod
);
    assign prod = {4'h0, x} * {4'h0, y};
endmodule

module mul8_seq (
    input  logic      clk,
    input  logic      rst,
    mul8_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [1:0]  step, step_nxt, first_step, seq_step;
    logic        last_step, skip_all;
    logic [7:0]  a_q, b_q;
    logic [15:0] acc, p_q, term;
    logic [3:0]  nib_a, nib_b;
    logic [7:0]  pp;

    // step[0] picks the high nibble of a, step[1] the high nibble of b.
    assign nib_a = step[0] ? a_q[7:4] : a_q[3:0];
    assign nib_b = step[1] ? b_q[7:4] : b_q[3:0];

    mul4x4 u_mul (.x(nib_a), .y(nib_b), .prod(pp));

    always_comb begin
        case (step)
            2'd0:       term = {8'h00, pp};
            2'd1, 2'd2: term = {4'h0, pp, 4'h0};
            default:    term = {pp, 8'h00};
        endcase
    end

`ifdef MUL8_ZSKIP_EN
    logic [3:0] mask_in, mask_q;

    assign mask_in = {(|bus.a[7:4]) & (|bus.b[7:4]),
                      (|bus.a[3:0]) & (|bus.b[7:4]),
                      (|bus.a[7:4]) & (|bus.b[3:0]),
                      (|bus.a[3:0]) & (|bus.b[3:0])};

    // Descending scans so the lowest qualifying step wins.
    always_comb begin
        first_step = 2'd0;
        skip_all   = (mask_in == 4'h0);
        seq_step   = step;
        last_step  = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (mask_in[i]) first_step = 2'(i);
            if (i > int'(step) && mask_q[i]) begin
                seq_step  = 2'(i);
                last_step = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                         mask_q <= 4'h0;
        else if (state == IDLE && bus.start) mask_q <= mask_in;
    end
`else
    assign first_step = 2'd0;
    assign skip_all   = 1'b0;
    assign seq_step   = step + 2'd1;
    assign last_step  = (step == 2'd3);
`endif

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            IDLE: if (bus.start) begin
                state_nxt = skip_all ? DONE : MUL;
                step_nxt  = first_step;
            end
            MUL: begin
                if (last_step) state_nxt = DONE;
                else           step_nxt  = seq_step;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= 2'd0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // The final partial goes straight into p, so acc never needs a fifth cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 8'h00;
            b_q <= 8'h00;
            acc <= 16'h0000;
            p_q <= 16'h0000;
        end else if (state == IDLE && bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
            acc <= 16'h0000;
            if (skip_all) p_q <= 16'h0000;
        end else if (state == MUL) begin
            if (last_step) p_q <= acc + term;
            else           acc <= acc + term;
        end
    end

    assign bus.busy      = (state == MUL);
    assign bus.done      = (state == DONE);
    assign bus.p         = p_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: directed cases from the test plan plus random operands.
// The reference is plain a*b, with latency taken from the count of nonzero nibble pairs.
module tb_mul8_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [15:0] p_prev = 16'h0000;

    mul8_seq_if ifc ();
    mul8_seq dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Number of multiply steps the block should spend on a*b.
    function automatic int exp_steps(input logic [7:0] av, input logic [7:0] bv);
        int n = 0;
        logic [3:0] na [2];
        logic [3:0] nb [2];
        na[0] = av[3:0]; na[1] = av[7:4];
        nb[0] = bv[3:0]; nb[1] = bv[7:4];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
`ifdef MUL8_ZSKIP_EN
                if (na[i] != 4'h0 && nb[j] != 4'h0) n++;
`else
                n++;
`endif
        return n;
    endfunction

    // Full operation. When inject >= 0, start with a=b=FF is held at edge E+inject+1.
    // That request lands mid-operation and must be ignored.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input int inject);
        int n;
        logic [15:0] exp;
        n   = exp_steps(av, bv);
        exp = {8'h00, av} * {8'h00, bv};
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = av; ifc.b = bv;
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({tag, "_busy"}, 16'(ifc.busy), 16'h1);
            check({tag, "_nodone"}, 16'(ifc.done), 16'h0);
            check({tag, "_phold"}, ifc.p, p_prev);
            ifc.a = 8'($urandom); ifc.b = 8'($urandom);
            ifc.start = 1'b0;
            if (k == inject) begin
                ifc.start = 1'b1; ifc.a = 8'hFF; ifc.b = 8'hFF;
            end
        end
        @(negedge clk);
        ifc.start = 1'b0;
        check({tag, "_done"}, 16'(ifc.done), 16'h1);
        check({tag, "_busy_lo"}, 16'(ifc.busy), 16'h0);
        check({tag, "_p"}, ifc.p, exp);
        p_prev = exp;
        @(negedge clk);
        check({tag, "_done_pulse"}, 16'(ifc.done), 16'h0);
        check({tag, "_p_keep"}, ifc.p, exp);
        @(negedge clk);
        check({tag, "_idle"}, 16'({ifc.busy, ifc.done}), 16'h0);
    endtask

    initial begin
        int n, last_idx, pulses;
        logic [7:0] ra, rb;
        ifc.start = 1'b0; ifc.a = 8'h00; ifc.b = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 16'(ifc.busy), 16'h0);
        check("rst_done", 16'(ifc.done), 16'h0);
        check("rst_p", ifc.p, 16'h0000);
        rst = 1'b0;

        run_op("max", 8'hFF, 8'hFF, -1);
        run_op("ignored_start", 8'h12, 8'h34, 1);
        run_op("zs_one", 8'h0F, 8'hF0, -1);
        run_op("zs_none", 8'h00, 8'h77, -1);
        run_op("max2", 8'hFF, 8'hFF, -1);

        // Abort mid-run: reset is seen at edge E+2 and held through edge E+3.
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 8'hAB; ifc.b = 8'hCD;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        check("abort_busy", 16'(ifc.busy), 16'(exp_steps(8'hAB, 8'hCD) > 0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_rst", 16'(ifc.busy), 16'h0);
        check("abort_done_rst", 16'(ifc.done), 16'h0);
        check("abort_p_rst", ifc.p, 16'h0000);
        @(negedge clk);
        check("abort_done_rst2", 16'(ifc.done), 16'h0);
        rst = 1'b0;
        p_prev = 16'h0000;
        @(negedge clk);
        check("abort_after", 16'({ifc.busy, ifc.done}), 16'h0);
        check("abort_p_after", ifc.p, 16'h0000);
        run_op("post_abort", 8'h03, 8'h05, -1);

        // Random operands, sometimes with zeroed nibbles and a mid-run start pulse
        for (int t = 0; t < 12; t++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            case ($urandom_range(0, 3))
                0: ra[3:0] = 4'h0;
                1: ra[7:4] = 4'h0;
                default: ;
            endcase
            case ($urandom_range(0, 3))
                0: rb[3:0] = 4'h0;
                1: rb[7:4] = 4'h0;
                default: ;
            endcase
            run_op("rand", ra, rb, $urandom_range(0, 5));
        end

        // Back-to-back: start held high, so the accept period is n+2 edges.
        n = exp_steps(8'h10, 8'h10);
        last_idx = 0;
        pulses = 0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.a = 8'h10; ifc.b = 8'h10;
        for (int idx = 1; idx <= 4 * (n + 2); idx++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) begin
                check("b2b_p", ifc.p, 16'h0100);
                if (pulses == 0) check("b2b_first", 16'(idx), 16'(n + 1));
                else             check("b2b_period", 16'(idx - last_idx), 16'(n + 2));
                last_idx = idx;
                pulses++;
            end
        end
        ifc.start = 1'b0;
        check("b2b_count", 16'(pulses), 16'd4);
        repeat (2) @(negedge clk);
        check("b2b_idle", 16'({ifc.busy, ifc.done}), 16'h0);
        check("b2b_p_keep", ifc.p, 16'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
